// File: rtl/ksa_pkg.sv
// Shared definitions for the Kogge-Stone adder family.
// Holds the default operand width, the derived prefix depth, the
// generate/propagate pair type and the prefix combine operator.
package ksa_pkg;

  localparam int KSA_WIDTH  = 16;
  localparam int KSA_STAGES = $clog2(KSA_WIDTH);

  // Generate/propagate pair carried through the prefix tree.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Associative prefix operator: hi is the more significant span.
  function automatic gp_t gp_combine(gp_t hi, gp_t lo);
    gp_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

endpackage

// File: rtl/ksa_black_cell.sv
// Kogge-Stone black cell: merges a (g,p) pair with the pair from the
// span immediately below it, producing the group (G,P) of the union.
module ksa_black_cell
  import ksa_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  gp_t hi_s;
  gp_t lo_s;
  gp_t res_s;

  assign hi_s.g = g_hi;
  assign hi_s.p = p_hi;
  assign lo_s.g = g_lo;
  assign lo_s.p = p_lo;

  assign res_s = gp_combine(hi_s, lo_s);

  assign g = res_s.g;
  assign p = res_s.p;

endmodule

// File: rtl/ksa_16bits.sv
// 16-bit Kogge-Stone parallel-prefix adder: {cout,out} = in1 + in2.
// Pre-process builds per-bit generate/propagate, a log2(WIDTH)-deep
// prefix tree of black cells forms every group generate, and the
// post-process XORs the carries back into the propagate bits.
// Optional feature macro: KSA_OUT_REG_EN
//   undefined (default): fully combinational, clk/rst ignored.
//   defined: {cout,out} registered on posedge clk, synchronous
//            active-high rst clears both, one cycle of latency.
module ksa_16bits
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam int STAGES = $clog2(WIDTH);

  logic [WIDTH-1:0] g_pre_s;
  logic [WIDTH-1:0] p_pre_s;
  logic [WIDTH-1:0] g_fin_s;
  logic [WIDTH-1:0] p_fin_s;
  logic [WIDTH-1:0] carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;

  // Per-bit generate and propagate.
  assign g_pre_s = in1 & in2;
  assign p_pre_s = in1 ^ in2;

  // Prefix tree: stage k combines each bit with the bit 2**k below it.
  // Bits below the span already hold their final group value and pass
  // straight through, so no path is longer than STAGES cells.
  genvar k, i;
  generate
    for (k = 0; k < STAGES; k++) begin : gen_stage
      logic [WIDTH-1:0] g_in_s;
      logic [WIDTH-1:0] p_in_s;
      logic [WIDTH-1:0] g_s;
      logic [WIDTH-1:0] p_s;

      if (k == 0) begin : gen_first
        assign g_in_s = g_pre_s;
        assign p_in_s = p_pre_s;
      end else begin : gen_next
        assign g_in_s = gen_stage[k-1].g_s;
        assign p_in_s = gen_stage[k-1].p_s;
      end

      for (i = 0; i < WIDTH; i++) begin : gen_bit
        if (i >= (1 << k)) begin : gen_black
          ksa_black_cell u_cell (
            .g_hi (g_in_s[i]),
            .p_hi (p_in_s[i]),
            .g_lo (g_in_s[i - (1 << k)]),
            .p_lo (p_in_s[i - (1 << k)]),
            .g    (g_s[i]),
            .p    (p_s[i])
          );
        end else begin : gen_pass
          assign g_s[i] = g_in_s[i];
          assign p_s[i] = p_in_s[i];
        end
      end
    end
  endgenerate

  // Final group values: g_fin_s[i] is the carry out of bit i.
  assign g_fin_s = gen_stage[STAGES-1].g_s;
  assign p_fin_s = gen_stage[STAGES-1].p_s;

  // Post-process: no carry-in, so bit 0 sees a zero carry.
  assign carry_s = {g_fin_s[WIDTH-2:0], 1'b0};
  assign sum_s   = p_pre_s ^ carry_s;
  assign cout_s  = g_fin_s[WIDTH-1];

`ifdef KSA_OUT_REG_EN

  // Final group propagate is not needed to form the sum.
  logic unused_s;
  assign unused_s = &{1'b0, p_fin_s};

  // Output register: reset clears the result and wins over a new sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= {WIDTH{1'b0}};
      cout <= 1'b0;
    end else begin
      out  <= sum_s;
      cout <= cout_s;
    end
  end

`else

  // Clock, reset and final group propagate have no role in this build.
  logic unused_s;
  assign unused_s = &{1'b0, clk, rst, p_fin_s};

  // Combinational output: the sum tracks the operands directly.
  always_comb begin
    out  = sum_s;
    cout = cout_s;
  end

`endif

endmodule

// File: tb/tb_ksa_16bits.sv
// Self-checking bench for ksa_16bits. A driver pushes the expected
// {cout,out} into a queue as it applies each operand pair; a monitor
// pops and compares one entry per cycle where a result is due (same
// cycle for the combinational build, one cycle later when
// KSA_OUT_REG_EN is defined).
module tb_ksa_16bits;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] out;
  logic        cout;

  logic [16:0] exp_q[$];
  logic        issued   = 1'b0;
  logic        issued_d = 1'b0;
  int          checks   = 0;
  int          failures = 0;

`ifdef KSA_OUT_REG_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  // Directed vectors and hand-computed {cout,out}.
  localparam int NDIR = 14;
  logic [15:0] dir_a [NDIR];
  logic [15:0] dir_b [NDIR];
  logic [16:0] dir_e [NDIR];

  ksa_16bits dut (
    .clk  (clk),
    .rst  (rst),
    .in1  (in1),
    .in2  (in2),
    .out  (out),
    .cout (cout)
  );

  always #5 clk = ~clk;

  // Track which cycles carried an issued operand pair, one cycle late.
  always @(posedge clk) issued_d <= issued;

  // Monitor: compare the DUT result against the oldest expectation.
  always @(negedge clk) begin
    logic check_now;
    check_now = REG_OUT ? issued_d : issued;
    if (check_now) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: got %h with no expected entry", {cout, out});
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({cout, out} !== e) begin
          failures++;
          $display("FAIL sum: in1=%h in2=%h got cout=%b out=%h expected cout=%b out=%h",
                   in1, in2, cout, out, e[16], e[15:0]);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [16:0] e);
    @(posedge clk);
    #1;
    in1    = a;
    in2    = b;
    issued = 1'b1;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [16:0] exp_rst;
    logic [15:0] ra;
    logic [15:0] rb;
    int          n;

    dir_a[0]  = 16'h0000; dir_b[0]  = 16'h0000; dir_e[0]  = 17'h0_0000;
    dir_a[1]  = 16'hFFFF; dir_b[1]  = 16'h0001; dir_e[1]  = 17'h1_0000;
    dir_a[2]  = 16'hAAAA; dir_b[2]  = 16'h5555; dir_e[2]  = 17'h0_FFFF;
    dir_a[3]  = 16'hFFFF; dir_b[3]  = 16'hFFFF; dir_e[3]  = 17'h1_FFFE;
    dir_a[4]  = 16'h8000; dir_b[4]  = 16'h8000; dir_e[4]  = 17'h1_0000;
    dir_a[5]  = 16'h1234; dir_b[5]  = 16'h4321; dir_e[5]  = 17'h0_5555;
    dir_a[6]  = 16'h00FF; dir_b[6]  = 16'h0001; dir_e[6]  = 17'h0_0100;
    dir_a[7]  = 16'h7FFF; dir_b[7]  = 16'h0001; dir_e[7]  = 17'h0_8000;
    dir_a[8]  = 16'hFFFF; dir_b[8]  = 16'h0000; dir_e[8]  = 17'h0_FFFF;
    dir_a[9]  = 16'h0F0F; dir_b[9]  = 16'hF0F1; dir_e[9]  = 17'h1_0000;
    dir_a[10] = 16'h1111; dir_b[10] = 16'h2222; dir_e[10] = 17'h0_3333;
    dir_a[11] = 16'hC000; dir_b[11] = 16'h4000; dir_e[11] = 17'h1_0000;
    dir_a[12] = 16'hABCD; dir_b[12] = 16'h1234; dir_e[12] = 17'h0_BE01;
    dir_a[13] = 16'hFFFE; dir_b[13] = 16'h0001; dir_e[13] = 17'h0_FFFF;

    // Reset phase: registered build must read zero, combinational
    // build ignores rst and shows the sum.
    rst = 1'b1;
    in1 = 16'h1234;
    in2 = 16'h4321;
    exp_rst = REG_OUT ? 17'h0_0000 : 17'h0_5555;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cout, out} !== exp_rst) begin
      failures++;
      $display("FAIL reset_state: got cout=%b out=%h expected cout=%b out=%h",
               cout, out, exp_rst[16], exp_rst[15:0]);
    end

    // Release reset with inputs held: sum appears one capture later.
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cout, out} !== 17'h0_5555) begin
      failures++;
      $display("FAIL after_reset: got cout=%b out=%h expected cout=0 out=5555", cout, out);
    end

    for (int d = 0; d < NDIR; d++) begin
      issue(dir_a[d], dir_b[d], dir_e[d]);
    end

    for (int r = 0; r < 10000; r++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      issue(ra, rb, {1'b0, ra} + {1'b0, rb});
    end

    @(posedge clk);
    #1;
    issued = 1'b0;

    // Bounded drain of outstanding expectations.
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
